// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: address width, reset PC, fetch entry layout, PC alignment.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instruction fetches are word aligned; the low two address bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: imem request/response, decode handshake, redirect input.
// Latency: n/a (wiring only).
// Backpressure: imem_req_ready stalls requests, instr_ready stalls decode delivery.
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            pcsrc;
  logic [XLEN-1:0] pc_target;

  // Fetch unit side.
  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, pcsrc, pc_target
  );

  // Memory plus decode side.
  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, pcsrc, pc_target
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; head is read straight from storage flops.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; caller must not push when full without a same-cycle pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(BUF_DEPTH):0] count
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem [BUF_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(BUF_DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage and pointers; flush drops every entry but leaves stale data in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Writing into a full buffer without freeing a slot would lose an entry.
  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop && !flush));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited imem requests, buffers and delivers instructions.
// Latency: response to decode 1 cycle; 0 cycles when FETCH_BYPASS_EN is defined and the buffer is empty.
// Backpressure: instr_ready stalls delivery; buffer plus in-flight requests never exceed BUF_DEPTH.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  bus
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic            started;

  logic [CW-1:0]   buf_count;
  logic [CW-1:0]   pcq_count;
  logic            buf_full, buf_empty, pcq_full, pcq_empty;
  fetch_entry_t    buf_head, pcq_head, buf_in, pcq_in;

  logic            req_fire;
  logic            rsp_keep;
  logic            bypass;
  logic            buf_push;
  logic            buf_pop;
  logic [CW-1:0]   occ_after_pop;

  // A response is kept only outside a redirect cycle and once all wrong-path responses are gone.
  assign rsp_keep = bus.imem_rsp_valid && !bus.pcsrc && (discard == '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = started && rsp_keep && buf_empty;
`else
  assign bypass = 1'b0;
`endif

  assign bus.instr_valid = !buf_empty || bypass;
  assign bus.instr       = bypass ? bus.imem_rsp_data : buf_head.instr;
  assign bus.instr_pc    = bypass ? pcq_head.pc : buf_head.pc;

  // A flush in the same cycle wins over the decode pop.
  assign buf_pop  = !buf_empty && bus.instr_ready && !bus.pcsrc;
  assign buf_push = rsp_keep && !(bypass && bus.instr_ready);

  // The entry leaving this cycle counts as free so a 1-cycle memory keeps the pipe full.
  assign occ_after_pop      = buf_count - CW'(buf_pop);
  assign bus.imem_req_valid = started && !bus.pcsrc &&
                              (({1'b0, occ_after_pop} + {1'b0, outstanding}) < (CW + 1)'(BUF_DEPTH));
  assign bus.imem_req_addr  = fetch_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign pcq_in = '{pc: fetch_pc, instr: '0};

  // Pair the returning word with the PC remembered when its request was accepted.
  always_comb begin
    buf_in       = pcq_head;
    buf_in.instr = bus.imem_rsp_data;
  end

  // PC, in-flight count and wrong-path discard count; a redirect overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      started     <= 1'b0;
    end else begin
      started     <= 1'b1;
      outstanding <= outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
      if (bus.pcsrc) begin
        fetch_pc <= align_pc(bus.pc_target);
        discard  <= outstanding - CW'(bus.imem_rsp_valid);
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + XLEN'(4);
        end
        if (bus.imem_rsp_valid && (discard != '0)) begin
          discard <= discard - 1'b1;
        end
      end
    end
  end

  fetch_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_instr_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.pcsrc),
    .push      (buf_push),
    .push_data (buf_in),
    .pop       (buf_pop),
    .head      (buf_head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  fetch_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.pcsrc),
    .push      (req_fire),
    .push_data (pcq_in),
    .pop       (rsp_keep),
    .head      (pcq_head),
    .full      (pcq_full),
    .empty     (pcq_empty),
    .count     (pcq_count)
  );

  // The pc queue tracks exactly the live (non-discarded) requests in flight.
  assert property (@(posedge clk) disable iff (rst) pcq_count == outstanding - discard);
  assert property (@(posedge clk) disable iff (rst) !(req_fire && pcq_full));
  assert property (@(posedge clk) disable iff (rst) !(rsp_keep && pcq_empty));
  assert property (@(posedge clk) disable iff (rst) !(buf_push && buf_full && !buf_pop));

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer side of the instruction/PC-select interface.
- Owns the PC, issues in-order word requests to instruction memory and buffers returned instructions.
- Presents instructions to the decode/control stage with a valid/ready handshake.
- Consumes the decoder's branch decision (pcsrc plus target) to redirect fetch and discard wrong-path instructions.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BUF_DEPTH, 2, instruction buffer entries; also the outstanding-request credit limit. Power of 2, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid. In order, exactly one per accepted request, at least 1 cycle after acceptance, no backpressure.
- imem_rsp_data  in  XLEN  instruction word.
- instr_valid  out  1  instruction available to decode.
- instr_ready  in  1  decode consumes.
- instr  out  XLEN  instruction word.
- instr_pc  out  XLEN  address of instr.
- pcsrc  in  1  redirect request, single-cycle pulse from control.
- pc_target  in  XLEN  redirect address; bits [1:0] ignored (forced 0).

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC, buffer empty, outstanding=0, discard=0. Outputs: imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0. The first request may assert in the first cycle after rst deasserts.
- Credit rule: imem_req_valid = !pcsrc && (occupancy + outstanding < BUF_DEPTH). imem_req_addr = fetch_pc.
- Request handshake (valid && ready): fetch_pc += 4, modulo 2^XLEN, wraps silently. Outstanding increments. Each request's pc is pushed to an internal pc queue of depth BUF_DEPTH.
- Response: outstanding decrements.
  - If discard>0: the response is dropped and discard decrements.
  - Otherwise {pc, data} is written to the buffer.
- Output: buffer head is registered onto instr/instr_pc/instr_valid. A response in cycle N is visible in cycle N+1 at the earliest. Pop on instr_valid && instr_ready.
- Simultaneous push and pop when full: legal. The credit rule prevents overflow; an overflow is an assertion failure.
- Redirect (pcsrc=1 at an edge), which has priority over everything else:
  - fetch_pc <= {pc_target[XLEN-1:2], 2'b00}.
  - Buffer and pc queue are flushed; instr_valid is 0 next cycle.
  - discard <= outstanding after counting any response arriving that same cycle, which is itself dropped.
  - No request is issued in the redirect cycle.
  - The first target request issues the following cycle.
- Back-to-back redirects: the later target wins; discard accumulates correctly.
- A pop in the redirect cycle is ignored; the flush dominates.
- Steady state with imem_req_ready=1, 1-cycle memory and BUF_DEPTH=2: sustains 1 instr/cycle.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined: when the buffer is empty, discard=0 and no redirect, an arriving response drives instr/instr_pc combinationally with instr_valid=1 in the same cycle. If instr_ready=1 it is consumed without being written to the buffer; otherwise it is buffered as normal. Redirect-cycle responses are never bypassed.
- Undefined: fully registered output, 1-cycle minimum response-to-decode latency.

Decomposition:
- Package fetch_pkg:
  - XLEN.
  - RESET_PC default.
  - INSTR_NOP = 32'h0000_0013.
  - typedef fetch_entry_t {pc, instr}.
  - function align_pc().
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t. Parameter BUF_DEPTH, ports for flush, push, pop, full, empty and count. Also instantiated for the pc queue.

Test Plan:
- Reset release, ready=1, 1-cycle memory, instr_ready=1 -> requests at 0x0, 0x4, 0x8 on consecutive cycles; instr_pc 0x0 in the first cycle after the first response; then 1 instr/cycle.
- instr_ready=0 for 10 cycles -> exactly 2 requests issued, imem_req_valid held 0, instr/instr_pc stable at 0x0. Release -> 0x0, 0x4 delivered in order, fetch resumes at 0x8.
- Redirect pcsrc=1, pc_target=0x103 with 2 requests outstanding -> both responses dropped, next request addr 0x100, first delivered instr_pc=0x100.
- pcsrc pulses on two consecutive cycles (targets 0x40, then 0x80) -> no instruction from 0x40 delivered, next instr_pc=0x80.
- fetch_pc=0xFFFF_FFFC -> next request addr 0x0000_0000.
- FETCH_BYPASS_EN defined, buffer empty, response in cycle N with instr_ready=1 -> instr_valid=1 in cycle N, no buffer write. Undefined -> instr_valid first in N+1.
